// File: rtl/q_readback_pkg.sv
`default_nettype none
// ============================================================================
// Module      : q_readback_pkg
// Description : Shared types and helpers for the q_readback state capture
//               and serial readback block.
//               - state_t     : readback FSM state encoding
//               - cnt_width() : width of the transfer counter for an N-slot
//                               frame (must be able to hold the value N)
//               - c_WIDTH_MIN / c_WIDTH_MAX : legal range of WIDTH
// Revision    : 1.0 - initial release
// ============================================================================
package q_readback_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam int c_WIDTH_MIN = 1;
    localparam int c_WIDTH_MAX = 64;

    // The counter reaches N on the final transfer, so it needs N+1 codes.
    function automatic int cnt_width(input int n);
        return $clog2(n + 1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/q_readback_if.sv
`default_nettype none
// ============================================================================
// Module      : q_readback_if
// Description : Capture/readback handshake bundle.
//   QCAP  : capture request (master -> slave)
//   QDI   : parallel state word to snapshot, WIDTH bits (master -> slave)
//   QEN   : downstream ready (master -> slave)
//   SDO   : serial data, LSB first (slave -> master)
//   SVLD  : SDO valid (slave -> master)
//   QBUSY : frame in progress, including the DONE cycle (slave -> master)
//   QDONE : one-cycle end-of-frame pulse (slave -> master)
// Revision    : 1.0 - initial release
// ============================================================================
interface q_readback_if #(
    parameter int WIDTH = 16
);
    logic             QCAP;
    logic [WIDTH-1:0] QDI;
    logic             QEN;
    logic             SDO;
    logic             SVLD;
    logic             QBUSY;
    logic             QDONE;

    modport master (
        output QCAP, QDI, QEN,
        input  SDO, SVLD, QBUSY, QDONE
    );

    modport slave (
        input  QCAP, QDI, QEN,
        output SDO, SVLD, QBUSY, QDONE
    );
endinterface
`default_nettype wire

// File: rtl/q_readback_shreg.sv
`default_nettype none
// ============================================================================
// Module      : q_readback_shreg
// Description : Loadable right-shifting snapshot register. On load it takes
//               the parallel word and, when PARITY=1, an even-parity bit
//               placed just above the data so it leaves last. Each shift
//               moves one bit toward the LSB and fills with zero.
//   clk     : clock
//   rst     : synchronous active-high reset, clears the register
//   i_load  : load i_din (and parity) this edge
//   i_shift : shift right by one this edge (ignored while loading)
//   i_din   : parallel word, WIDTH bits
//   o_lsb   : current serial bit (flop output)
// Revision    : 1.0 - initial release
// ============================================================================
module q_readback_shreg #(
    parameter int WIDTH  = 16,
    parameter int PARITY = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_load,
    input  logic             i_shift,
    input  logic [WIDTH-1:0] i_din,
    output logic             o_lsb
);

    localparam int c_LEN = WIDTH + PARITY;

    logic [c_LEN-1:0] w_load_val;
    logic [c_LEN-1:0] r_sh;

    generate
        if (PARITY != 0) begin : g_parity
            // XOR of the word makes data plus parity even weight.
            assign w_load_val = {^i_din, i_din};
        end else begin : g_no_parity
            assign w_load_val = i_din;
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            r_sh <= '0;
        end else if (i_load) begin
            r_sh <= w_load_val;
        end else if (i_shift) begin
            r_sh <= r_sh >> 1;
        end
    end

    assign o_lsb = r_sh[0];

endmodule
`default_nettype wire

// File: rtl/q_readback.sv
`default_nettype none
// ============================================================================
// Module      : q_readback
// Description : Snapshots a WIDTH-bit state word on a capture request and
//               streams it out LSB first under a valid/ready handshake,
//               optionally followed by an even-parity bit, then pulses
//               QDONE for one cycle. Every output is a flop output.
//   QCK  : clock, all state updates on the rising edge
//   QRT  : synchronous active-high reset, wins over a capture on the
//          same edge and aborts a frame without a QDONE pulse
//   bus  : q_readback_if.slave (QCAP, QDI, QEN in; SDO, SVLD, QBUSY,
//          QDONE out)
// Revision    : 1.0 - initial release
// ============================================================================
module q_readback
    import q_readback_pkg::*;
#(
    parameter int WIDTH  = 16,
    parameter int PARITY = 0
) (
    input  logic       QCK,
    input  logic       QRT,
    q_readback_if.slave bus
);

    localparam int              c_N    = WIDTH + PARITY;
    localparam int              c_CW   = cnt_width(c_N);
    localparam logic [c_CW-1:0] c_LAST = c_CW'(c_N - 1);
    localparam logic [c_CW-1:0] c_ONE  = c_CW'(1);

    generate
        if (WIDTH < c_WIDTH_MIN || WIDTH > c_WIDTH_MAX ||
            (PARITY != 0 && PARITY != 1)) begin : g_param_err
            $error("q_readback: WIDTH must be 1..64 and PARITY 0 or 1");
        end
    endgenerate

    state_t          r_state;
    state_t          w_state_nxt;
    logic [c_CW-1:0] r_cnt;
    logic [c_CW-1:0] w_cnt_nxt;
    logic            w_load;
    logic            w_shift;
    logic            w_sdo;
    logic            r_svld;
    logic            r_busy;
    logic            r_done;

    q_readback_shreg #(
        .WIDTH  (WIDTH),
        .PARITY (PARITY)
    ) u_shreg (
        .clk     (QCK),
        .rst     (QRT),
        .i_load  (w_load),
        .i_shift (w_shift),
        .i_din   (bus.QDI),
        .o_lsb   (w_sdo)
    );

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_load      = 1'b0;
        w_shift     = 1'b0;
        unique case (r_state)
            IDLE: begin
                if (bus.QCAP) begin
                    w_load      = 1'b1;
                    w_cnt_nxt   = '0;
                    w_state_nxt = SHIFT;
                end
            end
            SHIFT: begin
                // A transfer needs the downstream ready; otherwise hold.
                if (bus.QEN) begin
                    w_shift   = 1'b1;
                    w_cnt_nxt = r_cnt + c_ONE;
                    if (r_cnt == c_LAST) begin
                        w_state_nxt = DONE;
                    end
                end
            end
            DONE: begin
                w_state_nxt = IDLE;
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    // Status flags are registered from the next state so they line up
    // with the state they describe.
    always_ff @(posedge QCK) begin
        if (QRT) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_svld  <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_svld  <= (w_state_nxt == SHIFT);
            r_busy  <= (w_state_nxt != IDLE);
            r_done  <= (w_state_nxt == DONE);
        end
    end

    assign bus.SDO   = w_sdo;
    assign bus.SVLD  = r_svld;
    assign bus.QBUSY = r_busy;
    assign bus.QDONE = r_done;

endmodule
`default_nettype wire

// File: doc/q_readback.md
Q_READBACK -- requirements
Module: q_readback

Interface
REQ-001 Parameter WIDTH, default 16, number of captured state bits; legal range 1..64.
REQ-002 Parameter PARITY, default 0; when 1, an even-parity bit is appended after the data bits.
REQ-003 QCK  input  1  the one clock; all state updates on posedge QCK.
REQ-004 QRT  input  1  reset, synchronous and active-high.
REQ-005 QCAP  input  1  capture request; sampled only in IDLE.
REQ-006 QDI  input  WIDTH  parallel state bits (flop AQZ outputs) to snapshot.
REQ-007 QEN  input  1  downstream ready; a bit transfers on a cycle with SVLD=1 and QEN=1.
REQ-008 SDO  output  1  serial data, LSB first.
REQ-009 SVLD  output  1  SDO valid.
REQ-010 QBUSY  output  1  high from the cycle after capture through the DONE cycle.
REQ-011 QDONE  output  1  one-cycle pulse after the last bit transfers.

Function
REQ-012 States: IDLE, SHIFT, DONE; all outputs are registered.
REQ-013 IDLE with QCAP=1: at the next edge, QDI is loaded into the shift register, the count is cleared, and the state becomes SHIFT.
REQ-014 In SHIFT: SVLD=1, QBUSY=1, and SDO is the current LSB (or the parity bit in the final slot when PARITY=1).
REQ-015 Transfer (SVLD and QEN): shift right by one and increment the count; with QEN=0, SDO, SVLD and the count hold.
REQ-016 Frame length: N = WIDTH + PARITY transfers; the transfer that makes count = N moves the state to DONE.
REQ-017 Parity bit: XOR of the captured QDI word, so data bits plus parity have even weight.
REQ-018 DONE lasts exactly one cycle: QDONE=1, SVLD=0, QBUSY=1; the next state is IDLE unconditionally.
REQ-019 QCAP outside IDLE is ignored; it is not queued.
REQ-020 QCAP held high continuously: a new capture starts on the first IDLE cycle after DONE, with a 1-cycle IDLE gap.
REQ-021 QDI changes after capture do not affect a frame in progress.
REQ-022 Count width: clog2(N+1); no wrap is possible.
REQ-023 Minimum frame: WIDTH=1, PARITY=0, QEN=1 gives IDLE, SHIFT (1 cycle), DONE, IDLE.

Reset
REQ-024 QRT=1 at a posedge: state IDLE, SDO=0, SVLD=0, QBUSY=0, QDONE=0, count 0, shift register 0.
REQ-025 Reset mid-frame aborts the frame without a QDONE pulse.
REQ-026 QRT takes priority over QCAP on the same edge.
REQ-027 No asynchronous reset or set path.

Structure
REQ-028 Shared package q_readback_pkg holds:
  - the state enum (IDLE, SHIFT, DONE);
  - the count-width function;
  - the WIDTH legal-range constants.
REQ-029 One sub-module, q_readback_shreg, holds the loadable, enable-gated, right-shifting register plus parity generation.
REQ-030 The FSM and counter live in q_readback.

Verification
REQ-031 WIDTH=8, PARITY=0, QDI=0xA5, QCAP pulse, QEN=1 -> SDO sequence 1,0,1,0,0,1,0,1 on 8 SVLD cycles, then QDONE for 1 cycle.
REQ-032 WIDTH=8, PARITY=1, QDI=0x07, QEN=1 -> 9 transfers, 9th bit = 1, then QDONE.
REQ-033 WIDTH=4, QDI=0xC, QEN toggled 1,0,0,1,1,1 -> SDO holds during QEN=0; exactly 4 transfers 0,0,1,1; QDONE after the 4th.
REQ-034 WIDTH=8: QRT asserted after 3 transfers -> next cycle all outputs 0, no QDONE; a new QCAP then restarts from bit 0.
REQ-035 QCAP pulsed mid-frame and QDI changed mid-frame -> frame data unchanged, no second frame starts.
REQ-036 QCAP held high, WIDTH=2, QEN=1 -> repeating pattern SHIFT x2, DONE, IDLE; QDONE period 4 cycles.
